// File: rtl/inst_mem_responder.sv
// Instruction-memory responder for the IF stage: fixed-latency fetch with
// cancel-on-redirect, busy freeze indication and a program-load write port.
module inst_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        cancel,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_instr;
  logic [31:0]     r_mem [DEPTH];

  logic [AW-1:0]   w_idx;
  logic [AW-1:0]   w_ld_idx;
  logic            w_accept;
  logic            w_unused;

  assign w_idx    = addr[AW+1:2];
  assign w_ld_idx = ld_addr[AW+1:2];
  assign w_unused = ^{addr, ld_addr};

  // A redirect (cancel) in WAIT frees the slot so the new target can be taken.
  assign w_accept = req & ((r_state == IDLE) | (r_state == RESP) |
                           ((r_state == WAIT) & cancel));

  always_ff @(posedge clk) begin
    if (ld_en) r_mem[w_ld_idx] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_instr <= '0;
    end else if (w_accept) begin
      r_idx <= w_idx;
      r_cnt <= CW'(LATENCY - 1);
      if (LATENCY == 1) begin
        r_instr <= r_mem[w_idx];
        r_state <= RESP;
      end else begin
        r_state <= WAIT;
      end
    end else begin
      case (r_state)
        WAIT: begin
          if (cancel) begin
            r_state <= IDLE;
          end else if (r_cnt == CW'(1)) begin
            r_instr <= r_mem[r_idx];
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instr       = r_instr;
  assign busy        = (r_state == WAIT);
  assign instr_valid = (r_state == RESP) & ~cancel;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench: one LATENCY=1 and one LATENCY=3 responder share all inputs;
// each table row gives the inputs for a cycle and the outputs expected in it.
module tb_inst_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        cancel = 1'b0;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  logic [31:0] instr1, instr3;
  logic        valid1, valid3, busy1, busy3;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  inst_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .cancel(cancel),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .instr(instr1), .instr_valid(valid1), .busy(busy1)
  );

  inst_mem_responder #(.DEPTH(1024), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .cancel(cancel),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .instr(instr3), .instr_valid(valid3), .busy(busy3)
  );

  typedef struct {
    logic        rst, req;
    logic [31:0] addr;
    logic        cancel, ld_en;
    logic [31:0] ld_addr, ld_data;
    logic        chk;
    logic [31:0] i1;
    logic        v1, b1;
    logic [31:0] i3;
    logic        v3, b3;
  } vec_t;

  localparam logic [31:0] WA = 32'hE3A01005;
  localparam logic [31:0] WB = 32'hE2811001;
  localparam logic [31:0] WC = 32'h11112222;
  localparam logic [31:0] WD = 32'h33334444;
  localparam logic [31:0] WE = 32'h55556666;
  localparam logic [31:0] DB = 32'hDEADBEEF;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, q, input logic [31:0] a,
                              input logic c, le, input logic [31:0] la, ldd,
                              input logic ck, input logic [31:0] i1,
                              input logic v1, b1, input logic [31:0] i3,
                              input logic v3, b3);
    vec_t v;
    v.rst = r; v.req = q; v.addr = a; v.cancel = c; v.ld_en = le;
    v.ld_addr = la; v.ld_data = ldd; v.chk = ck;
    v.i1 = i1; v.v1 = v1; v.b1 = b1; v.i3 = i3; v.v3 = v3; v.b3 = b3;
    return v;
  endfunction

  task automatic chk(input string name, input int unsigned row,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
      // rst req addr    cncl ld  ld_addr  ld_data chk  i1 v1 b1   i3 v3 b3
    tbl.push_back(mk(1, 0, 32'h0,    0, 0, 32'h0,  32'h0, 0, '0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, '0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,    0, 1, 32'h0,  WA,    1, '0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,    0, 1, 32'h4,  WB,    1, '0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,    0, 1, 32'h8,  WC,    1, '0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,    0, 1, 32'hC,  WD,    1, '0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,    0, 1, 32'h10, WE,    1, '0, 0, 0, '0, 0, 0));
    // back-to-back fetches 0x0, 0x4, 0x8
    tbl.push_back(mk(0, 1, 32'h0,    0, 0, 32'h0,  32'h0, 1, '0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h4,    0, 0, 32'h0,  32'h0, 1, WA, 1, 0, '0, 0, 1));
    tbl.push_back(mk(0, 1, 32'h8,    0, 0, 32'h0,  32'h0, 1, WB, 1, 0, '0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WC, 1, 0, WA, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WC, 0, 0, WA, 0, 0));
    // single fetch 0x4
    tbl.push_back(mk(0, 1, 32'h4,    0, 0, 32'h0,  32'h0, 1, WC, 0, 0, WA, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WB, 1, 0, WA, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WB, 0, 0, WA, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WB, 0, 0, WB, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WB, 0, 0, WB, 0, 0));
    // fetch 0x0 then redirect to 0x10
    tbl.push_back(mk(0, 1, 32'h0,    0, 0, 32'h0,  32'h0, 1, WB, 0, 0, WB, 0, 0));
    tbl.push_back(mk(0, 1, 32'h10,   1, 0, 32'h0,  32'h0, 1, WA, 0, 0, WB, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WE, 1, 0, WB, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WE, 0, 0, WB, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WE, 0, 0, WE, 1, 0));
    // read/write collision on word 2, then cancel in RESP / WAIT
    tbl.push_back(mk(0, 1, 32'h8,    0, 1, 32'h8,  DB,    1, WE, 0, 0, WE, 0, 0));
    tbl.push_back(mk(0, 1, 32'h8,    0, 0, 32'h0,  32'h0, 1, WC, 1, 0, WE, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,    1, 0, 32'h0,  32'h0, 1, DB, 0, 0, WE, 0, 1));
    // address wrap, then reset during WAIT (with a competing req)
    tbl.push_back(mk(0, 1, 32'h1000, 0, 0, 32'h0,  32'h0, 1, DB, 0, 0, WE, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WA, 1, 0, WE, 0, 1));
    tbl.push_back(mk(1, 1, 32'h4,    0, 0, 32'h0,  32'h0, 1, WA, 0, 0, WE, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, '0, 0, 0, '0, 0, 0));
    // cancel in IDLE does not block the request
    tbl.push_back(mk(0, 1, 32'hC,    1, 0, 32'h0,  32'h0, 1, '0, 0, 0, '0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WD, 1, 0, '0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WD, 0, 0, '0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WD, 0, 0, WD, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,    0, 0, 32'h0,  32'h0, 1, WD, 0, 0, WD, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; req = tbl[i].req; addr = tbl[i].addr;
      cancel = tbl[i].cancel; ld_en = tbl[i].ld_en;
      ld_addr = tbl[i].ld_addr; ld_data = tbl[i].ld_data;
      #2;
      if (tbl[i].chk) begin
        chk("instr1", i, instr1, tbl[i].i1);
        chk("valid1", i, 32'(valid1), 32'(tbl[i].v1));
        chk("busy1",  i, 32'(busy1),  32'(tbl[i].b1));
        chk("instr3", i, instr3, tbl[i].i3);
        chk("valid3", i, 32'(valid3), 32'(tbl[i].v3));
        chk("busy3",  i, 32'(busy3),  32'(tbl[i].b3));
      end
    end

    // Continuous req at 0x4: LATENCY=1 answers every cycle, LATENCY=3 every third.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      rst = 1'b0; req = 1'b1; addr = 32'h4; cancel = 1'b0; ld_en = 1'b0;
      #2;
      chk("tp_valid1", 100 + k, 32'(valid1), 32'(k >= 1));
      chk("tp_busy1",  100 + k, 32'(busy1),  32'(0));
      chk("tp_valid3", 100 + k, 32'(valid3), 32'(k == 3 || k == 6));
      chk("tp_busy3",  100 + k, 32'(busy3),  32'(k == 1 || k == 2 || k == 4 || k == 5));
      if (k >= 1) chk("tp_instr1", 100 + k, instr1, WB);
      if (k == 3 || k == 6) chk("tp_instr3", 100 + k, instr3, WB);
    end
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
